// File: rtl/vrf_addr_pkg.sv
// vrf_addr_pkg: shared types and SEW helpers for the per-lane VRF address generator.
package vrf_addr_pkg;
  typedef enum logic [1:0] {SEW8 = 2'b00, SEW16 = 2'b01, SEW32 = 2'b10, SEW_ILL = 2'b11} sew_e;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_state_e;
  function automatic int sew_shift(sew_e s);
    return s == SEW8 ? 2 : s == SEW16 ? 1 : 0;
  endfunction
  function automatic int cnt_limit(sew_e s, int vloc);
    return (vloc << sew_shift(s)) - 1;
  endfunction
endpackage

// File: rtl/vrf_addr_base_shreg.sv
// vrf_addr_base_shreg: per-group base registers; cur is the group being walked, nxt the one after it.
module vrf_addr_base_shreg #(
  parameter int AW = 9,
  parameter int GW = 3,
  parameter int N  = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load,
  input  logic            shift,
  input  logic            up,
  input  logic [GW-1:0]   lmul,
  input  logic [N*AW-1:0] start,
  input  logic [AW-1:0]   offset,
  output logic [AW-1:0]   first,
  output logic [AW-1:0]   cur,
  output logic [AW-1:0]   nxt
);
  logic [AW-1:0] r [N];
  logic [GW-1:0] fsel;
  assign fsel  = up ? '0 : lmul;
  assign first = up ? start[0 +: AW] + offset : start[int'(lmul)*AW +: AW] - offset;
  assign cur   = r[fsel];
  assign nxt   = up ? r[1] : r[lmul - GW'(1)];
  // ascending walks pull higher groups toward slot 0; descending pushes lower groups toward slot lmul
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) for (int g = 0; g < N; g++) r[g] <= '0;
    else if (load) for (int g = 0; g < N; g++) r[g] <= GW'(g) == fsel ? first : start[g*AW +: AW];
    else if (shift && up) for (int g = 0; g < N - 1; g++) r[g] <= r[g+1];
    else if (shift) for (int g = 1; g < N; g++) r[g] <= r[g-1];
endmodule

// File: rtl/vrf_addr_gen.sv
// vrf_addr_gen: per-lane VRF address generator walking LMUL register groups in up/down order.
module vrf_addr_gen
  import vrf_addr_pkg::*;
#(
  parameter int MEM_DEPTH         = 512,
  parameter int VREG_LOC_PER_LANE = 8,
  parameter int MAX_LMUL          = 8,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int GW = $clog2(MAX_LMUL),
  localparam int CW = $clog2(MAX_LMUL*VREG_LOC_PER_LANE*4+1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [MAX_LMUL*AW-1:0] start_addr_i,
  input  logic [GW-1:0]        lmul_i,
  input  logic [1:0]           sew_i,
  input  logic                 up_down_i,
  input  logic [AW-1:0]        slide_offset_i,
  input  logic [CW-1:0]        elem_cnt_i,
  input  logic                 flush_i,
  output logic [AW-1:0]        addr_o,
  output logic                 addr_valid_o,
  input  logic                 addr_ready_i,
  output logic                 addr_last_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 busy_o
);
  localparam int SW = $clog2(4*VREG_LOC_PER_LANE);
  fsm_state_e state, state_nxt;
  sew_e sew;
  logic acc, legal, nz, start, hs, fin, adv, grp_end, shift, up_q;
  logic [GW-1:0] lmul_q;
  logic [1:0] sh_i, sh_q;
  logic [SW-1:0] lim_i, lim_q, sub_q, sub_nxt;
  logic [CW-1:0] cap, tot_i, tot_q, idx_q;
  logic [AW-1:0] first, cur, nxt;
  assign sew         = sew_e'(sew_i);
  assign cmd_ready_o = state == IDLE;
  assign busy_o      = state != IDLE;
  assign acc         = cmd_ready_o & cmd_valid_i & !flush_i;
  assign legal       = sew != SEW_ILL;
  assign nz          = elem_cnt_i != '0;
  assign start       = acc & legal & nz;
  assign hs          = addr_valid_o & addr_ready_i;
  assign fin         = hs & addr_last_o;
  assign adv         = hs & !addr_last_o & !flush_i;
  assign grp_end     = up_q ? sub_q == lim_q : sub_q == '0;
  assign shift       = adv & grp_end;
  assign sh_i        = 2'(sew_shift(sew));
  assign lim_i       = SW'(cnt_limit(sew, VREG_LOC_PER_LANE));
  assign cap         = ((CW'(lmul_i) + CW'(1)) * CW'(VREG_LOC_PER_LANE)) << sh_i;
  assign tot_i       = elem_cnt_i < cap ? elem_cnt_i : cap;
  assign sub_nxt     = up_q ? (grp_end ? '0 : sub_q + SW'(1)) : (grp_end ? lim_q : sub_q - SW'(1));
  vrf_addr_base_shreg #(.AW(AW), .GW(GW), .N(MAX_LMUL)) u_base (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load   (start),
    .shift  (shift),
    .up     (start ? up_down_i : up_q),
    .lmul   (start ? lmul_i : lmul_q),
    .start  (start_addr_i),
    .offset (slide_offset_i),
    .first  (first),
    .cur    (cur),
    .nxt    (nxt)
  );
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = flush_i ? IDLE : state == IDLE ? (start ? RUN : IDLE) : (fin ? IDLE : RUN);
  end
  // addr_o is computed one step ahead so the address port comes straight from a flop
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      addr_o       <= '0;
      addr_valid_o <= 1'b0;
      addr_last_o  <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      lmul_q       <= '0;
      up_q         <= 1'b0;
      sh_q         <= '0;
      lim_q        <= '0;
      tot_q        <= '0;
      idx_q        <= '0;
      sub_q        <= '0;
    end else begin
      addr_valid_o <= state_nxt == RUN;
      done_o       <= !flush_i & (fin | (acc & legal & !nz));
      err_o        <= acc & !legal;
      if (start) begin
        lmul_q      <= lmul_i;
        up_q        <= up_down_i;
        sh_q        <= sh_i;
        lim_q       <= lim_i;
        tot_q       <= tot_i;
        idx_q       <= '0;
        sub_q       <= up_down_i ? '0 : lim_i;
        addr_o      <= first + AW'((up_down_i ? '0 : lim_i) >> sh_i);
        addr_last_o <= tot_i == CW'(1);
      end else if (adv) begin
        idx_q       <= idx_q + CW'(1);
        sub_q       <= sub_nxt;
        addr_o      <= (shift ? nxt : cur) + AW'(sub_nxt >> sh_q);
        addr_last_o <= idx_q + CW'(2) == tot_q;
      end else if (state_nxt == IDLE) addr_last_o <= 1'b0;
    end
endmodule

// File: tb/tb_vrf_addr_gen.sv
// tb_vrf_addr_gen: scoreboard bench; stimulus queues expected addresses, a monitor checks each handshake.
module tb_vrf_addr_gen;
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, up_down = 1'b1, flush = 1'b0, ready = 1'b1;
  logic [71:0] start_addr = '0;
  logic [2:0] lmul = '0;
  logic [1:0] sew = '0;
  logic [8:0] offset = '0, elem = '0, addr;
  logic addr_valid, addr_last, done, err, busy;
  logic [9:0] exp_q [$];
  int checks = 0, errors = 0, done_cnt = 0, d0 = 0;
  always #5 clk = ~clk;
  vrf_addr_gen dut (
    .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .start_addr_i(start_addr), .lmul_i(lmul), .sew_i(sew), .up_down_i(up_down),
    .slide_offset_i(offset), .elem_cnt_i(elem), .flush_i(flush), .addr_o(addr),
    .addr_valid_o(addr_valid), .addr_ready_i(ready), .addr_last_o(addr_last),
    .done_o(done), .err_o(err), .busy_o(busy)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0d req=%0d", nm, act, req);
    end
  endtask
  task automatic push(input int a, input bit l);
    exp_q.push_back({9'(a), l});
  endtask
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst_i && addr_valid && ready && !flush) begin
      if (exp_q.size() == 0) chk("unexpected_addr", 32'(addr), 32'h7fffffff);
      else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("addr", 32'(addr), 32'(e[9:1]));
        chk("last", 32'(addr_last), 32'(e[0]));
      end
    end
  end
  task automatic issue(input bit u, input logic [1:0] s, input logic [2:0] l,
                       input int b0, input int b1, input int off, input int n);
    int t = 0;
    while (!cmd_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) chk("cmd_ready_timeout", 32'(cmd_ready), 1);
    start_addr = '0;
    start_addr[8:0] = 9'(b0);
    start_addr[17:9] = 9'(b1);
    up_down = u; sew = s; lmul = l; offset = 9'(off); elem = 9'(n);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask
  task automatic wait_done(input int exp_cyc);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < 300);
    chk("done_seen", 32'(done), 1);
    if (exp_cyc > 0) chk("done_cycle", 32'(c), 32'(exp_cyc));
    chk("ready_at_done", 32'(cmd_ready), 1);
    chk("busy_at_done", 32'(busy), 0);
    chk("drained", 32'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_valid", 32'(addr_valid), 0);
    chk("rst_last", 32'(addr_last), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(addr), 0);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) push(16 + i, i == 7);
    issue(1, 2'b10, 0, 16, 0, 0, 8);
    @(negedge clk);
    chk("lat_valid", 32'(addr_valid), 1);
    chk("lat_addr", 32'(addr), 16);
    chk("lat_busy", 32'(busy), 1);
    wait_done(8);
    push(40, 0); push(40, 0); push(40, 0); push(40, 0); push(41, 0); push(41, 1);
    issue(1, 2'b00, 0, 40, 0, 0, 6);
    wait_done(-1);
    for (int i = 0; i < 8; i++) push(204 - i, 0);
    for (int i = 0; i < 8; i++) push(107 - i, i == 7);
    issue(0, 2'b10, 1, 100, 200, 3, 16);
    wait_done(17);
    push(510, 0); push(511, 0); push(0, 0); push(1, 1);
    issue(1, 2'b10, 0, 510, 0, 0, 4);
    wait_done(-1);
    for (int i = 0; i < 16; i++) push(5 + i / 2, 0);
    for (int i = 0; i < 16; i++) push(32 + i / 2, i == 15);
    issue(1, 2'b01, 1, 0, 32, 5, 40);
    wait_done(-1);
    for (int i = 0; i < 8; i++) push(8 + i, 0);
    for (int i = 0; i < 8; i++) push(64 + i, i == 7);
    issue(1, 2'b10, 1, 8, 64, 0, 100);
    wait_done(-1);
    for (int i = 0; i < 5; i++) push(300 + i, i == 4);
    issue(1, 2'b10, 0, 300, 0, 0, 5);
    @(posedge clk); @(posedge clk); #1;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_addr", 32'(addr), 302);
      chk("stall_valid", 32'(addr_valid), 1);
      @(posedge clk);
    end
    #1 ready = 1'b1;
    wait_done(-1);
    push(50, 0); push(51, 0);
    issue(1, 2'b10, 0, 50, 0, 0, 8);
    @(posedge clk); @(posedge clk); #1;
    ready = 1'b0; flush = 1'b1; d0 = done_cnt;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(addr_valid), 0);
    chk("flush_busy", 32'(busy), 0);
    chk("flush_ready", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    elem = 9'd4; cmd_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_cmd_busy", 32'(busy), 0);
    chk("flush_cmd_valid", 32'(addr_valid), 0);
    repeat (2) @(negedge clk);
    chk("flush_no_done", 32'(done_cnt), 32'(d0));
    chk("flush_drained", 32'(exp_q.size()), 0);
    @(posedge clk); #1;
    ready = 1'b1;
    push(60, 0); push(61, 1);
    issue(1, 2'b10, 0, 60, 0, 0, 2);
    wait_done(3);
    issue(1, 2'b10, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("zero_done", 32'(done), 1);
    chk("zero_valid", 32'(addr_valid), 0);
    chk("zero_busy", 32'(busy), 0);
    @(posedge clk); #1;
    issue(1, 2'b11, 0, 0, 0, 0, 5);
    @(negedge clk);
    chk("ill_err", 32'(err), 1);
    chk("ill_done", 32'(done), 0);
    chk("ill_valid", 32'(addr_valid), 0);
    @(negedge clk);
    chk("ill_err_pulse", 32'(err), 0);
    @(posedge clk); #1;
    ready = 1'b0;
    issue(1, 2'b10, 0, 0, 0, 0, 20);
    @(posedge clk); #2;
    d0 = done_cnt;
    rst_i = 1'b0;
    #1;
    chk("arst_valid", 32'(addr_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'(cmd_ready), 1);
    chk("arst_addr", 32'(addr), 0);
    @(posedge clk); #1;
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_no_done", 32'(done_cnt), 32'(d0));
    chk("arst_idle", 32'(addr_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
